sender_arb: RTL and testbench

Arbiter that shares the single UART byte sender between the output-commit path and the debug word dumper. The output path gets zero-latency pass-through so that its commit handshake stays combinational. A debug word is latched and serialized as 4 bytes, LSB first, and is never interleaved with output bytes. A starvation counter bounds how long a pending debug word can wait behind a continuous output stream.

---
 rtl/sender_arb.sv | 120 ++++++++++++
 tb/tb_sender_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sender_arb.sv
// sender_arb: shares one UART byte sender between the output-commit path
// (zero-latency pass-through) and a debug word dumper that serializes a
// latched 32-bit word as four bytes, LSB first, never interleaved with
// output bytes. A starvation counter bounds how long a pending debug word
// can wait behind a continuous output stream.
module sender_arb #(
    parameter int STARVE_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        out_valid,
    input  logic [7:0]  out_data,
    output logic        out_ready,
    input  logic        dbg_valid,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    input  logic        sender_ready,
    output logic        sender_valid,
    output logic [7:0]  sender_in,
    output logic        busy
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {
        S_OUT,
        S_DBG
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    cnt;
    logic [1:0]    cnt_next;
    logic [31:0]   shift;
    logic [31:0]   shift_next;
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_next;

    logic in_dbg;
    logic dbg_take;
    logic out_xfer;

    // While reset is held the outputs already behave as in OUT, so a reset
    // during a debug word stops presenting its bytes in that very cycle.
    assign in_dbg   = (state == S_DBG) && !reset;
    assign out_xfer = out_valid && out_ready;

    // State register: synchronous reset returns to OUT with everything cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_OUT;
            cnt    <= 2'd0;
            shift  <= 32'd0;
            starve <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            shift  <= shift_next;
            starve <= starve_next;
        end
    end

    // Next-state logic: latch a debug word, step through its bytes, track starvation.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        shift_next  = shift;
        starve_next = starve;
        case (state)
            S_OUT: begin
                if (dbg_take) begin
                    shift_next  = dbg_data;
                    cnt_next    = 2'd0;
                    starve_next = '0;
                    state_next  = S_DBG;
                end else if (!dbg_valid) begin
                    starve_next = '0;
                end else if (out_xfer && (starve != STARVE_MAX)) begin
                    starve_next = starve + 1'b1;
                end
            end
            S_DBG: begin
                if (sender_ready) begin
                    shift_next = shift >> 8;
                    cnt_next   = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        cnt_next   = 2'd0;
                        state_next = S_OUT;
                    end
                end
            end
            default: begin
                state_next = S_OUT;
            end
        endcase
    end

    // Output logic: combinational pass-through in OUT, current debug byte in DBG.
    always_comb begin
        out_ready    = 1'b0;
        dbg_ready    = 1'b0;
        dbg_take     = 1'b0;
        sender_valid = 1'b0;
        sender_in    = 8'd0;
        busy         = 1'b0;
        if (in_dbg) begin
            sender_valid = 1'b1;
            sender_in    = shift[7:0];
            busy         = 1'b1;
        end else begin
            dbg_ready    = !out_valid || (starve == STARVE_MAX);
            dbg_take     = dbg_valid && dbg_ready;
            sender_valid = out_valid && !dbg_take;
            sender_in    = out_data;
            out_ready    = sender_ready && !dbg_take;
        end
    end

endmodule

// File: tb/tb_sender_arb.sv
// tb_sender_arb: drives three sender_arb instances (STARVE_LIMIT 16, 2, 0)
// with shared stimulus. A byte-queue reference model per instance predicts
// every cycle's handshake outputs and the byte stream on the sender line;
// a monitor pops and compares those predictions at each falling edge.
module tb_sender_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        sender_ready;

    logic        out_ready_w    [3];
    logic        dbg_ready_w    [3];
    logic        sender_valid_w [3];
    logic [7:0]  sender_in_w    [3];
    logic        busy_w         [3];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       dbg;
    } xfer_t;

    typedef struct packed {
        logic sv;
        logic oready;
        logic dready;
        logic busy;
    } ctrl_t;

    xfer_t      byte_q [3][$];
    ctrl_t      ctrl_q [3][$];
    logic [7:0] pend   [3][$];
    int         waits  [3];

    always #5 clk = ~clk;

    sender_arb #(.STARVE_LIMIT(16)) dut16 (
        .clk(clk), .reset(reset),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready_w[0]),
        .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready_w[0]),
        .sender_ready(sender_ready), .sender_valid(sender_valid_w[0]),
        .sender_in(sender_in_w[0]), .busy(busy_w[0])
    );

    sender_arb #(.STARVE_LIMIT(2)) dut2 (
        .clk(clk), .reset(reset),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready_w[1]),
        .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready_w[1]),
        .sender_ready(sender_ready), .sender_valid(sender_valid_w[1]),
        .sender_in(sender_in_w[1]), .busy(busy_w[1])
    );

    sender_arb #(.STARVE_LIMIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready_w[2]),
        .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready_w[2]),
        .sender_ready(sender_ready), .sender_valid(sender_valid_w[2]),
        .sender_in(sender_in_w[2]), .busy(busy_w[2])
    );

    function automatic int limitOf(input int i);
        case (i)
            0:       return 16;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    // Reference model: a non-empty queue of pending debug bytes means the
    // sender belongs to the debug word; otherwise the output path has it,
    // unless a debug word is waiting and the output path has used up its
    // allowance of transfers.
    task automatic modelStep(input int i);
        ctrl_t c;
        xfer_t x;
        logic  take;
        logic  forced;
        if (!reset && pend[i].size() != 0) begin
            c.sv     = 1'b1;
            c.oready = 1'b0;
            c.dready = 1'b0;
            c.busy   = 1'b1;
            if (sender_ready) begin
                x.data = pend[i].pop_front();
                x.dbg  = 1'b1;
                byte_q[i].push_back(x);
            end
        end else begin
            forced   = (waits[i] >= limitOf(i));
            c.dready = !out_valid || forced;
            take     = dbg_valid && c.dready;
            c.oready = sender_ready && !take;
            c.sv     = out_valid && !take;
            c.busy   = 1'b0;
            if (c.sv && sender_ready) begin
                x.data = out_data;
                x.dbg  = 1'b0;
                byte_q[i].push_back(x);
            end
            if (!reset) begin
                if (take) begin
                    waits[i] = 0;
                    for (int k = 0; k < 4; k++) pend[i].push_back(dbg_data[8*k +: 8]);
                end else if (!dbg_valid) begin
                    waits[i] = 0;
                end else if (out_valid && c.oready && waits[i] < limitOf(i)) begin
                    waits[i] = waits[i] + 1;
                end
            end
        end
        ctrl_q[i].push_back(c);
        if (reset) begin
            pend[i].delete();
            waits[i] = 0;
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and record the
    // model's predictions for that cycle.
    task automatic applyStimulus(input logic r, input logic ov, input logic [7:0] od,
                                 input logic dv, input logic [31:0] dd, input logic sr);
        @(posedge clk);
        #1;
        reset        = r;
        out_valid    = ov;
        out_data     = od;
        dbg_valid    = dv;
        dbg_data     = dd;
        sender_ready = sr;
        for (int i = 0; i < 3; i++) modelStep(i);
    endtask

    task automatic checkBit(input string name, input int inst, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s inst=%0d t=%0t actual=%b required=%b", name, inst, $time, act, exp);
        end
    endtask

    task automatic checkByte(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s inst=%0d t=%0t actual=%02h required=%02h", name, inst, $time, act, exp);
        end
    endtask

    // Compare one instance's outputs for the current cycle against the queues.
    task automatic checkOutput(input int i);
        ctrl_t c;
        xfer_t x;
        if (ctrl_q[i].size() == 0) return;
        c = ctrl_q[i].pop_front();
        checkBit("sender_valid", i, sender_valid_w[i], c.sv);
        checkBit("out_ready", i, out_ready_w[i], c.oready);
        checkBit("dbg_ready", i, dbg_ready_w[i], c.dready);
        checkBit("busy", i, busy_w[i], c.busy);
        if (sender_valid_w[i] === 1'b1 && sender_ready === 1'b1) begin
            if (byte_q[i].size() == 0) begin
                checkBit("unexpected_byte", i, 1'b1, 1'b0);
            end else begin
                x = byte_q[i].pop_front();
                checkByte("sender_in", i, sender_in_w[i], x.data);
                checkBit("byte_source", i, busy_w[i], x.dbg);
            end
        end
    endtask

    // Monitor: checks every instance at each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) checkOutput(i);
        end
    end

    initial begin
        reset        = 1'b1;
        out_valid    = 1'b0;
        out_data     = 8'd0;
        dbg_valid    = 1'b0;
        dbg_data     = 32'd0;
        sender_ready = 1'b0;
        for (int i = 0; i < 3; i++) waits[i] = 0;

        applyStimulus(1, 0, 8'h00, 0, 32'h0, 0);
        applyStimulus(1, 0, 8'h00, 0, 32'h0, 0);
        applyStimulus(0, 0, 8'h00, 0, 32'h0, 0);

        $display("[TB] idle pass-through");
        applyStimulus(0, 1, 8'h41, 0, 32'h0, 0);
        applyStimulus(0, 1, 8'h41, 0, 32'h0, 1);
        applyStimulus(0, 0, 8'h00, 0, 32'h0, 1);

        $display("[TB] debug word alone");
        applyStimulus(0, 0, 8'h00, 1, 32'hDDCCBBAA, 1);
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 8'h00, 0, 32'h0, 1);

        $display("[TB] backpressure in debug word");
        applyStimulus(0, 0, 8'h00, 1, 32'hDDCCBBAA, 1);
        applyStimulus(0, 1, 8'h55, 0, 32'h0, 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 8'h56, 0, 32'h0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 1, 8'h57 + 8'(k), 0, 32'h0, 1);
        applyStimulus(0, 0, 8'h00, 0, 32'h0, 1);

        $display("[TB] starvation with continuous output stream");
        for (int k = 0; k < 32; k++)
            applyStimulus(0, 1, 8'(k + 8'h10), 1, 32'h0A0B0C0D + 32'(k), 1);
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 8'h00, 0, 32'h0, 1);

        $display("[TB] reset in the middle of a debug word");
        applyStimulus(0, 0, 8'h00, 1, 32'h87654321, 1);
        applyStimulus(0, 0, 8'h00, 0, 32'h0, 1);
        applyStimulus(0, 0, 8'h00, 0, 32'h0, 1);
        applyStimulus(1, 0, 8'h00, 0, 32'h0, 1);
        applyStimulus(0, 0, 8'h00, 0, 32'h0, 1);
        applyStimulus(0, 0, 8'h00, 1, 32'h13579BDF, 1);
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 8'h00, 0, 32'h0, 1);

        $display("[TB] random traffic");
        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 9) < 7,
                          8'($urandom),
                          $urandom_range(0, 3) != 0,
                          $urandom,
                          $urandom_range(0, 3) != 0);
        end

        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 8'h00, 0, 32'h0, 1);
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) checkBit("bytes_drained", i, byte_q[i].size() == 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
